param_stream_ctrl: RTL and testbench
====================================

PARAM_STREAM_CTRL -- requirements
Module: param_stream_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 512: width of one ROM word (BIAS_PRECISION_0 * BIAS_TENSOR_SIZE_DIM_0).
REQ-002 Parameter DEPTH, default 32: words per pass, addresses 0..DEPTH-1.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH)+1: ROM address width.
REQ-004 Parameter REPEAT_WIDTH, default 8: width of the pass-count configuration.
REQ-005 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port start, input, 1: one-cycle request to begin a stream; sampled only in IDLE.
REQ-008 Port cfg_repeat, input, REPEAT_WIDTH: number of full passes over the ROM, latched at accepted start; 0 is treated as 1.
REQ-009 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-010 Port done, output, 1: one-cycle pulse after the final beat is accepted.
REQ-011 Port rom_addr, output, ADDR_WIDTH: address to the parameter ROM.
REQ-012 Port rom_ce, output, 1: ROM clock enable; it gates both ROM pipeline stages.
REQ-013 Port rom_q, input, DATA_WIDTH: ROM read data, valid 2 enabled cycles after the address.
REQ-014 Port data_out, output, DATA_WIDTH: streamed word; equals rom_q combinationally.
REQ-015 Port data_out_valid, output, 1: data_out holds a real ROM word.
REQ-016 Port data_out_ready, input, 1: downstream accepts when valid and ready are both high.
REQ-017 Port data_out_last, output, 1: qualifies the beat at address DEPTH-1 of each pass.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN on start; latch cfg_repeat; address counter = 0; pass counter = 0.
REQ-020 Stall rule: rom_ce = !(data_out_valid && !data_out_ready); rom_ce is also high in IDLE.
REQ-021 The pipeline advances only when rom_ce is high; the address, tags and counters hold otherwise.
REQ-022 In RUN, each cycle with rom_ce high issues rom_addr and sets a stage-0 valid tag.
REQ-023 Address increment: after issuing DEPTH-1, the address wraps to 0 and the pass counter increments.
REQ-024 Tag pipeline: two tag stages, each carrying valid and last, shifted when rom_ce is high; data_out_valid and data_out_last come from stage 2.
REQ-025 Latency: the first valid beat appears 2 cycles after the first RUN cycle when there is no backpressure.
REQ-026 RUN->DRAIN in the cycle that issues the final address (last pass, address DEPTH-1); no further tags are set.
REQ-027 DRAIN->DONE when no tag is valid and the final beat has been accepted.
REQ-028 DONE: done = 1 for one cycle, then IDLE; busy = 0 in IDLE and DONE.
REQ-029 start outside IDLE is ignored.
REQ-030 When start is asserted in the DONE cycle, it is ignored.
REQ-031 Throughput: with data_out_ready held high, one beat per cycle and no bubbles, including across pass boundaries.
REQ-032 Beat count: exactly DEPTH*max(cfg_repeat,1) beats per stream, in address order 0..DEPTH-1 repeated.
REQ-033 data_out_ready may be low while data_out_valid is high; data_out is then held stable because the ROM is frozen by rom_ce.
REQ-034 Pass counter is REPEAT_WIDTH bits; the comparison uses the latched count, so there is no overflow.

Reset
REQ-035 On rst: state = IDLE, all tags = 0, address = 0, pass counter = 0.
REQ-036 Outputs during and after reset: busy = 0, done = 0, data_out_valid = 0, data_out_last = 0.
REQ-037 Reset is asynchronous assertion and synchronous-to-clk deassertion.
REQ-038 Reset mid-stream aborts immediately; no done pulse is produced.
REQ-039 ROM data registers are not reset; the valid tags mask stale rom_q.

Structure
REQ-040 Package param_stream_pkg holds the state enum type and the ROM_LATENCY = 2 constant.
REQ-041 The tag pipeline depth is derived from ROM_LATENCY.
REQ-042 One sub-module, param_stream_addr_gen, holds the address and pass counters with wrap and last-issue flag.
REQ-043 The sub-module ports are: advance, clear, cfg_repeat, addr, last_issue.

Verification
REQ-044 Streaming: DEPTH=4, cfg_repeat=1, ready=1 -> beats at cycles 2..5 after start, words 0,1,2,3, last on word 3, done at cycle 6.
REQ-045 Backpressure: ready low for 3 cycles at beat 1 -> word 1 is held stable, no loss or duplication, rom_ce low for those 3 cycles.
REQ-046 Repeat: cfg_repeat=3 -> 12 beats with no bubbles, last on beats 4, 8 and 12, single done; cfg_repeat=0 -> 4 beats.
REQ-047 Illegal start: start pulsed during RUN and during the DONE cycle -> ignored, beat count unchanged.
REQ-048 Reset mid-stream: rst asserted after beat 2 -> valid=0 and busy=0 immediately, no done; a new start yields a full correct stream.
REQ-049 Random ready (50%) over 8 streams -> scoreboard matches ROM image order exactly.

Source files
------------

// File: rtl/param_stream_pkg.sv
// Shared types and constants for the parameter-ROM streaming controller.
// The tag pipeline depth is derived from ROM_LATENCY.
package param_stream_pkg;

  localparam int ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Sideband that travels alongside each ROM read.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/param_stream_addr_gen.sv
// Address and pass counters for the parameter stream: wraps at DEPTH-1 and
// flags the issue of the final address of the final pass.
module param_stream_addr_gen
  import param_stream_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    clear,
  input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    last_issue
);

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [REPEAT_WIDTH-1:0] repeat_q, repeat_d;
  logic                    wrap;

  assign wrap       = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  // repeat_q is never zero, so repeat_q-1 is the index of the final pass.
  assign last_issue = wrap && (pass_q == (repeat_q - REPEAT_WIDTH'(1)));
  assign addr       = addr_q;

  always_comb begin
    addr_d   = addr_q;
    pass_d   = pass_q;
    repeat_d = repeat_q;
    if (clear) begin
      addr_d   = '0;
      pass_d   = '0;
      repeat_d = (cfg_repeat == '0) ? REPEAT_WIDTH'(1) : cfg_repeat;
    end else if (advance) begin
      if (wrap) begin
        addr_d = '0;
        pass_d = pass_q + REPEAT_WIDTH'(1);
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      pass_q   <= '0;
      repeat_q <= REPEAT_WIDTH'(1);
    end else begin
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      repeat_q <= repeat_d;
    end
  end

endmodule

// File: rtl/param_stream_ctrl.sv
// Streams DEPTH ROM words per pass, cfg_repeat passes, through a valid/ready
// port; backpressure freezes the ROM pipeline through rom_ce.
module param_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int REPEAT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic                    data_out_last
);

  state_e state_q;
  logic   busy_q;
  logic   done_q;
  tag_t   tag_q [ROM_LATENCY];
  tag_t   issue_tag;
  logic   start_accept;
  logic   issue;
  logic   last_issue;
  logic   pending;

  assign data_out_valid = tag_q[ROM_LATENCY-1].valid;
  assign data_out_last  = tag_q[ROM_LATENCY-1].last;
  assign data_out       = rom_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // A held beat freezes the whole ROM pipeline so rom_q stays on that word.
  assign rom_ce       = !(data_out_valid && !data_out_ready);
  assign start_accept = (state_q == ST_IDLE) && start;
  assign issue        = (state_q == ST_RUN) && rom_ce;

  assign issue_tag.valid = issue;
  assign issue_tag.last  = issue && (rom_addr == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < ROM_LATENCY - 1; i++) begin
      pending = pending | tag_q[i].valid;
    end
  end

  param_stream_addr_gen #(
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REPEAT_WIDTH(REPEAT_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .advance   (issue),
    .clear     (start_accept),
    .cfg_repeat(cfg_repeat),
    .addr      (rom_addr),
    .last_issue(last_issue)
  );

  // NOTE: only the tags are reset; the ROM data path is not, because a
  // cleared valid tag already masks whatever stale word rom_q carries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (rom_ce) begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue && last_issue) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // With rom_ce high the output beat, if any, is accepted this edge.
          if (rom_ce && !pending) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Bench for param_stream_ctrl: ROM model, queue scoreboard with a decoupled
// monitor, directed timing/backpressure/reset cases and random-ready streams.
module tb_param_stream_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int RW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] cfg_repeat;
  logic          busy, done;
  logic [AW-1:0] rom_addr;
  logic          rom_ce;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;

  always #5 clk = ~clk;

  param_stream_ctrl #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .REPEAT_WIDTH(RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_repeat    (cfg_repeat),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_ce        (rom_ce),
    .rom_q         (rom_q),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last (data_out_last)
  );

  // Two-stage ROM, both stages gated by rom_ce.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rom_s1;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= mem[rom_addr];
      rom_q  <= rom_s1;
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   beat_cnt    = 0;
  int   stall_cnt   = 0;
  int   done_total  = 0;
  int   ready_mode  = 0;  // 0: always ready, 1: random, 2: stall 3 cycles at beat 1
  int   stall_left  = 0;
  bit   stall_used  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented beat against the scoreboard head and
  // pops on acceptance; a stalled beat is compared again each cycle.
  always @(negedge clk) begin
    if (done) done_total++;
    if (data_out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", data_out_valid, 1'b0);
      end else begin
        check("beat_data", data_out, exp_q[0].data);
        check("beat_last", data_out_last, exp_q[0].last);
        if (data_out_ready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end else begin
          check("rom_ce_stall", rom_ce, 1'b0);
          stall_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: data_out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (stall_left > 0) begin
          data_out_ready = 1'b0;
          stall_left--;
        end else if (!stall_used && data_out_valid && beat_cnt == 1) begin
          data_out_ready = 1'b0;
          stall_left     = 2;
          stall_used     = 1'b1;
        end else begin
          data_out_ready = 1'b1;
        end
      end
      default: data_out_ready = 1'b1;
    endcase
  end

  // Runs one stream. Edge k=0 is the edge that samples start; outputs are
  // sampled 1 time unit after each edge.
  task automatic run_stream(input int rep, input bit timed, input bit poke_start);
    int n;
    int first_v, last_v, vcnt, done_k, dones, busy_cnt;
    n = DEPTH * ((rep == 0) ? 1 : rep);
    for (int p = 0; p < n; p++) begin
      exp_q.push_back('{data: mem[p % DEPTH], last: (p % DEPTH) == DEPTH - 1});
    end
    beat_cnt = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    cfg_repeat = RW'(rep);
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_repeat = RW'($urandom_range(0, 255));
    first_v = -1; last_v = -1; vcnt = 0; done_k = -1; dones = 0; busy_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      if (data_out_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        vcnt++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (done_k < 0) begin
          done_k = k;
          check("busy_in_done", busy, 1'b0);
          if (poke_start) start = 1'b1;
        end
      end
      if (poke_start && k == 1) begin
        check("busy_in_run", busy, 1'b1);
        start = 1'b1;
      end
      if (done_k >= 0 && k >= done_k + 4) break;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_seen", (done_k >= 0), 1'b1);
    check("single_done", dones, 1);
    check("beats_accepted", beat_cnt, n);
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_after_done", busy, 1'b0);
    if (timed) begin
      check("first_beat_cycle", first_v, 2);
      check("last_beat_cycle", last_v, n + 1);
      check("no_bubbles", vcnt, n);
      check("done_cycle", done_k, n + 2);
      check("busy_cycles", busy_cnt, n + 2);
    end
    exp_q.delete();
  endtask

  initial begin
    int dones_before;
    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    rst = 1'b1; start = 1'b0; cfg_repeat = '0; data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_last", data_out_last, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", data_out_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Plain streams with timing, including repeat and zero-repeat.
    run_stream(1, 1'b1, 1'b0);
    run_stream(3, 1'b1, 1'b0);
    run_stream(0, 1'b1, 1'b0);

    // Start pulsed during RUN and during the DONE cycle.
    run_stream(1, 1'b1, 1'b1);

    // Backpressure on beat 1.
    ready_mode = 2; stall_used = 1'b0; stall_cnt = 0;
    run_stream(1, 1'b0, 1'b0);
    check("stall_cycles", stall_cnt, 3);
    ready_mode = 0;

    // Reset mid-stream after two beats.
    dones_before = done_total;
    for (int p = 0; p < DEPTH; p++) begin
      exp_q.push_back('{data: mem[p], last: p == DEPTH - 1});
    end
    beat_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_repeat = RW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && beat_cnt < 2; k++) begin
      @(posedge clk); #1;
    end
    check("beats_before_reset", beat_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", data_out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_abort", done_total, dones_before);
    run_stream(1, 1'b1, 1'b0);

    // Random ready over eight streams.
    ready_mode = 1;
    for (int s = 0; s < 8; s++) begin
      run_stream($urandom_range(0, 3), 1'b0, 1'b0);
    end
    ready_mode = 0;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
